rptr_fwft: RTL and testbench

Read-side pointer and output stage of the JTAG async FIFO, in the read clock domain.
- Synchronizes the write domain's Gray write pointer into `rclk` and derives `empty` and the occupancy.
- Advances the binary read address and returns a registered Gray read pointer for the write side's full check.
- Presents FIFO data through a first-word-fall-through output register with a valid/ready handshake.
- Pointer convention matches the write side: `ADDR_WIDTH`-bit pointers with no wrap bit. Empty is `raddr == waddr`; full is `waddr + 1 == raddr`. Usable depth is `2^ADDR_WIDTH - 1`.

---
 rtl/rptr_fwft.sv | 101 ++++++++++
 tb/tb_rptr_fwft.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rptr_fwft.sv
// Read-side pointer and first-word-fall-through output stage of the async FIFO.
// Synchronizes the Gray write pointer, tracks the read address and owns the output register.
module rptr_fwft #(
   parameter int ADDR_WIDTH  = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  rclk,
   input  logic                  r_nrst,
   input  logic [ADDR_WIDTH-1:0] wptr,
   input  logic [DATA_WIDTH-1:0] rdata_mem,
   input  logic                  rready,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic [ADDR_WIDTH-1:0] rptr,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  empty,
   output logic [ADDR_WIDTH-1:0] rcount
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   // Output register state; FULL_OUT is exactly the rvalid condition.
   typedef enum logic {
      EMPTY_OUT = 1'b0,
      FULL_OUT  = 1'b1
   } out_state_t;

   out_state_t state, state_next;

   logic [SYNC_STAGES-1:0][ADDR_WIDTH-1:0] sync_q;
   logic [ADDR_WIDTH-1:0] sync_wptr;
   logic [ADDR_WIDTH-1:0] sync_waddr;
   logic [ADDR_WIDTH-1:0] raddr_next;
   logic                  pop;

   function automatic logic [ADDR_WIDTH-1:0] flex_bin2gray(
      input logic [ADDR_WIDTH-1:0] v,
      input logic                  bin2gray
   );
      logic [ADDR_WIDTH-1:0] r;
      r = v ^ (v >> 1);
      if (!bin2gray) begin
         r[ADDR_WIDTH-1] = v[ADDR_WIDTH-1];
         for (int i = ADDR_WIDTH - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ v[i];
         end
      end
      return r;
   endfunction

   // wptr moves one Gray step at a time, so each stage sees at most one bit in flight.
   always_ff @(posedge rclk or negedge r_nrst) begin
      if (!r_nrst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], wptr};
      end
   end

   assign sync_wptr  = sync_q[SYNC_STAGES-1];
   assign sync_waddr = flex_bin2gray(sync_wptr, 1'b0);
   assign empty      = (sync_waddr == raddr);
   assign rcount     = sync_waddr - raddr;
   assign raddr_next = raddr + ADDR_ONE;
   assign rvalid     = (state == FULL_OUT);

   // Handshake: a word transfers on an rclk edge where rvalid && rready; while rvalid is
   // high and rready low, rdata is frozen; rready is ignored while rvalid is low.
   always_ff @(posedge rclk or negedge r_nrst) begin
      if (!r_nrst) begin
         state <= EMPTY_OUT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pop        = !empty && ((state == EMPTY_OUT) || rready);
      case (state)
         EMPTY_OUT: if (pop) state_next = FULL_OUT;
         FULL_OUT:  if (rready && !pop) state_next = EMPTY_OUT;
         default:   state_next = EMPTY_OUT;
      endcase
   end

   // rptr is registered so the write domain never samples a combinational glitch.
   always_ff @(posedge rclk or negedge r_nrst) begin
      if (!r_nrst) begin
         raddr <= '0;
         rptr  <= '0;
         rdata <= '0;
      end else if (pop) begin
         raddr <= raddr_next;
         rptr  <= flex_bin2gray(raddr_next, 1'b1);
         rdata <= rdata_mem;
      end
   end

endmodule

// File: tb/tb_rptr_fwft.sv
// Bench for rptr_fwft: memory and write side modelled in the bench, outputs compared
// every cycle against a count-based reference model plus directed scenario checks.
module tb_rptr_fwft;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int SS = 2;

   logic          rclk;
   logic          r_nrst;
   logic [AW-1:0] wptr;
   logic [DW-1:0] rdata_mem;
   logic          rready;
   logic [AW-1:0] raddr;
   logic [AW-1:0] rptr;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          empty;
   logic [AW-1:0] rcount;

   logic [DW-1:0] mem [16];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: unbounded word counts, a sampling delay line, the output slot.
   int            wcnt;
   int            rd;
   int            consumed;
   int            hist[$];
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic [DW-1:0] data_log[$];
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] prev_rptr;

   rptr_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
      .rclk      (rclk),
      .r_nrst    (r_nrst),
      .wptr      (wptr),
      .rdata_mem (rdata_mem),
      .rready    (rready),
      .raddr     (raddr),
      .rptr      (rptr),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .empty     (empty),
      .rcount    (rcount)
   );

   assign rdata_mem = mem[raddr];

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] to_gray(input int b);
      logic [AW-1:0] v;
      v = AW'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic put_word(input logic [DW-1:0] d);
      mem[wcnt % 16] = d;
      data_log.push_back(d);
      exp_q.push_back(d);
      wcnt++;
   endtask

   task automatic publish();
      wptr = to_gray(wcnt);
   endtask

   task automatic model_edge();
      int  sw_old;
      bit  pop;
      sw_old = hist[0];
      pop = (sw_old != rd) && (!m_valid || rready);
      if (m_valid && rready) consumed++;
      if (pop) begin
         m_data  = data_log[rd];
         m_valid = 1'b1;
         rd++;
      end else if (m_valid && rready) begin
         m_valid = 1'b0;
      end
      void'(hist.pop_front());
      hist.push_back(wcnt);
   endtask

   task automatic compare_all();
      int sw;
      sw = hist[0];
      chk("rvalid", rvalid, m_valid);
      chk("rdata", rdata, m_data);
      chk("raddr", raddr, rd % 16);
      chk("rptr", rptr, to_gray(rd));
      chk("empty", empty, (sw == rd));
      chk("rcount", rcount, (sw - rd) & 15);
      if (rptr != prev_rptr) chk("rptr_one_bit", $countones(rptr ^ prev_rptr), 1);
      prev_rptr = rptr;
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step();
      if (rvalid && rready && exp_q.size() > 0) chk("order", rdata, exp_q.pop_front());
      @(posedge rclk);
      model_edge();
      #1;
      compare_all();
      @(negedge rclk);
   endtask

   task automatic do_reset();
      r_nrst = 1'b0;
      wptr   = '0;
      rready = 1'b0;
      wcnt = 0; rd = 0; consumed = 0;
      m_valid = 1'b0; m_data = '0; prev_rptr = '0;
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(0);
      data_log.delete();
      exp_q.delete();
      #1;
      chk("rst_rvalid", rvalid, 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_rptr", rptr, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_empty", empty, 1);
      chk("rst_rcount", rcount, 0);
      @(negedge rclk);
      r_nrst = 1'b1;
   endtask

   initial begin
      int low;
      int wraps;
      int total;
      logic [AW-1:0] pa, pp;
      logic [DW-1:0] w0, w1, w2;

      r_nrst = 1'b0;
      rready = 1'b0;
      wptr   = '0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      @(negedge rclk);
      do_reset();

      // Single word appears on the third edge after wptr is sampled.
      put_word(32'hDEADBEEF);
      publish();
      step(); step(); step();
      chk("single_rvalid", rvalid, 1);
      chk("single_rdata", rdata, 32'hDEADBEEF);
      chk("single_raddr", raddr, 1);
      chk("single_rptr", rptr, 1);
      chk("single_empty", empty, 1);
      rready = 1'b1;
      step();
      chk("single_consumed", rvalid, 0);
      rready = 1'b0;

      // Backpressure: exactly one pop while rready is low, data frozen.
      do_reset();
      w0 = $urandom; w1 = $urandom; w2 = $urandom;
      put_word(w0); publish(); step();
      put_word(w1); publish(); step();
      put_word(w2); publish(); step();
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_hold", rdata, w0);
         chk("bp_hold_valid", rvalid, 1);
      end
      chk("bp_raddr", raddr, 1);
      chk("bp_rcount", rcount, 2);
      rready = 1'b1;
      step();
      chk("bp_word1", rdata, w1);
      step();
      chk("bp_word2", rdata, w2);
      step();
      chk("bp_done_rvalid", rvalid, 0);
      chk("bp_done_empty", empty, 1);
      chk("bp_done_rcount", rcount, 0);

      // Random stream of 40 words through two address wraps.
      do_reset();
      wraps = 0;
      total = 0;
      for (int cyc = 0; cyc < 2000 && consumed < 40; cyc++) begin
         if (total < 40 && (wcnt - rd) < 15 && $urandom_range(0, 3) != 0) begin
            put_word($urandom);
            publish();
            total++;
         end
         rready = 1'($urandom_range(0, 1));
         pa = raddr;
         pp = rptr;
         step();
         if (pa == 4'd15 && raddr == 4'd0) begin
            wraps++;
            chk("wrap_rptr_before", pp, 4'b1000);
            chk("wrap_rptr_after", rptr, 4'b0000);
         end
      end
      chk("stream_consumed", consumed, 40);
      chk("stream_wraps", wraps, 2);

      // Reset mid-stream while a word sits in the output register.
      rready = 1'b0;
      put_word(32'h1234_5678); publish(); step();
      put_word(32'h9ABC_DEF0); publish(); step(); step();
      chk("pre_reset_rvalid", rvalid, 1);
      do_reset();

      // Empty race: new write lands the same cycle the last word is consumed.
      w0 = $urandom; w1 = $urandom;
      put_word(w0); publish();
      step(); step(); step();
      chk("race_first_valid", rvalid, 1);
      put_word(w1); publish();
      rready = 1'b1;
      step();
      low = 0;
      while (rvalid == 1'b0 && low < 10) begin
         low++;
         step();
      end
      chk("race_gap", low, SS);
      chk("race_data", rdata, w1);
      rready = 1'b0;

      // Full-depth drain: fifteen words published with one Gray step 0000 -> 1000.
      do_reset();
      for (int i = 0; i < 15; i++) put_word($urandom);
      publish();
      step(); step();
      chk("full_rcount", rcount, 15);
      chk("full_raddr", raddr, 0);
      chk("full_empty", empty, 0);
      rready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         chk("drain_valid", rvalid, 1);
      end
      chk("drain_empty", empty, 1);
      chk("drain_raddr", raddr, 15);
      chk("drain_rptr", rptr, 4'b1000);
      step();
      chk("drain_last_consumed", rvalid, 0);
      rready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
